// File: rtl/pc_cmd_pkg.sv
// Shared definitions for the command-frame parser.
//   - pc_state_e : parser FSM states
//   - PC_*       : default framing codes and valid ranges
//   - pc_cmd_t   : one queued command {addr, req} at the default byte width
package pc_cmd_pkg;

   localparam int         PC_DATA_W    = 8;
   localparam logic [7:0] PC_HDR_CODE  = 8'hFF;
   localparam logic [7:0] PC_TAIL_CODE = 8'h7F;
   localparam logic [7:0] PC_ADDR_MIN  = 8'h01;
   localparam logic [7:0] PC_ADDR_MAX  = 8'h20;
   localparam logic [7:0] PC_REQ_MIN   = 8'h81;
   localparam logic [7:0] PC_REQ_MAX   = 8'h88;

   typedef enum logic [2:0] {IDLE, HEADER, ADDR, REQ, TAIL} pc_state_e;

   typedef struct packed {
      logic [PC_DATA_W-1:0] addr;
      logic [PC_DATA_W-1:0] req;
   } pc_cmd_t;

endpackage

// File: rtl/pc_cmd_fifo.sv
// Synchronous FIFO with a registered head output.
//   clk, rst  : clock, asynchronous active-low reset
//   push, din : write request / data (ignored when full unless a pop frees a slot)
//   pop       : read request (ignored when empty)
//   dout      : registered head entry, 0 when empty
//   empty/full: status
module pc_cmd_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr, rd_ptr, wr_nxt, rd_nxt;
   logic             do_push, do_pop;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign wr_nxt  = wr_ptr + (AW+1)'(do_push);
   assign rd_nxt  = rd_ptr + (AW+1)'(do_pop);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         wr_ptr <= wr_nxt;
         rd_ptr <= rd_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

   // Head register tracks what the head will be after this cycle's push/pop,
   // so a write into an empty queue is visible on the very next cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                          dout <= '0;
      else if (rd_nxt == wr_nxt)         dout <= '0;
      else if (do_push && rd_nxt == wr_ptr) dout <= din;
      else                               dout <= mem[rd_nxt[AW-1:0]];
   end

endmodule

// File: rtl/pc_cmd_parser.sv
// Command-frame parser: HDR, ADDR+, REQ+, TAIL byte frames from the UART Rx
// strobe are validated and committed as {addr, req} into a small FIFO.
// Optional feature macro: PC_CMD_PARSER_TIMEOUT_EN (inter-byte timeout).
//   clk, rst            : clock, asynchronous active-low reset
//   rx_data, rx_valid   : received byte and its one-cycle strobe
//   cmd_addr, cmd_req   : registered FIFO head
//   cmd_valid, cmd_ready: output handshake (pop on valid && ready)
//   frame_err           : pulse on a framing violation
//   frame_drop          : pulse when a completed frame finds the FIFO full
//   timeout             : pulse when the inter-byte timeout fires
//   frame_cnt, err_cnt  : saturating statistics
module pc_cmd_parser
   import pc_cmd_pkg::*;
#(
   parameter int                DATA_W      = PC_DATA_W,
   parameter logic [DATA_W-1:0] HDR_CODE    = DATA_W'(PC_HDR_CODE),
   parameter logic [DATA_W-1:0] TAIL_CODE   = DATA_W'(PC_TAIL_CODE),
   parameter logic [DATA_W-1:0] ADDR_MIN    = DATA_W'(PC_ADDR_MIN),
   parameter logic [DATA_W-1:0] ADDR_MAX    = DATA_W'(PC_ADDR_MAX),
   parameter logic [DATA_W-1:0] REQ_MIN     = DATA_W'(PC_REQ_MIN),
   parameter logic [DATA_W-1:0] REQ_MAX     = DATA_W'(PC_REQ_MAX),
   parameter int                CMD_DEPTH   = 4,
   parameter logic [15:0]       TIMEOUT_CYC = 16'd50000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] rx_data,
   input  logic              rx_valid,
   output logic [DATA_W-1:0] cmd_addr,
   output logic [DATA_W-1:0] cmd_req,
   output logic              cmd_valid,
   input  logic              cmd_ready,
   output logic              frame_err,
   output logic              frame_drop,
   output logic              timeout,
   output logic [15:0]       frame_cnt,
   output logic [15:0]       err_cnt
);

   pc_state_e         state, state_nxt;
   logic [DATA_W-1:0] addr_q, req_q;
   logic              ld_addr, ld_req, commit, err, to_fire;
   logic              is_hdr, is_tail, in_req, in_addr;
   logic              fifo_empty, fifo_full, accept;
   logic [2*DATA_W-1:0] fifo_dout;

   // Code matches take priority over ranges, and the request range over the
   // address range, so overlapping configurations decode deterministically.
   assign is_hdr  = (rx_data == HDR_CODE);
   assign is_tail = (rx_data == TAIL_CODE);
   assign in_req  = !is_hdr && !is_tail && (rx_data >= REQ_MIN) && (rx_data <= REQ_MAX);
   assign in_addr = !is_hdr && !is_tail && !in_req &&
                    (rx_data >= ADDR_MIN) && (rx_data <= ADDR_MAX);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      ld_addr   = 1'b0;
      ld_req    = 1'b0;
      commit    = 1'b0;
      err       = 1'b0;
      if (rx_valid) begin
         unique case (state)
            IDLE:   if (is_hdr) state_nxt = HEADER;
            HEADER: begin
               if (in_addr) begin
                  ld_addr   = 1'b1;
                  state_nxt = ADDR;
               end else if (!is_hdr) begin
                  err       = 1'b1;
                  state_nxt = IDLE;
               end
            end
            ADDR: begin
               if (in_req) begin
                  ld_req    = 1'b1;
                  state_nxt = REQ;
               end else if (in_addr) begin
                  ld_addr   = 1'b1;
               end else begin
                  err       = 1'b1;
                  state_nxt = IDLE;
               end
            end
            REQ: begin
               if (is_tail) begin
                  commit    = 1'b1;
                  state_nxt = TAIL;
               end else if (in_req) begin
                  ld_req    = 1'b1;
               end else begin
                  err       = 1'b1;
                  state_nxt = IDLE;
               end
            end
            TAIL: begin
               if (is_hdr)        state_nxt = HEADER;
               else if (!is_tail) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end else if (to_fire) begin
         state_nxt = IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_q <= '0;
         req_q  <= '0;
      end else if (state_nxt == IDLE) begin
         addr_q <= '0;
         req_q  <= '0;
      end else begin
         if (ld_addr) addr_q <= rx_data;
         if (ld_req)  req_q  <= rx_data;
      end
   end

   // A full FIFO still accepts when the consumer pops in the same cycle.
   assign accept = !fifo_full || cmd_ready;

   pc_cmd_fifo #(
      .WIDTH (2*DATA_W),
      .DEPTH (CMD_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (commit),
      .pop   (cmd_ready),
      .din   ({addr_q, req_q}),
      .dout  (fifo_dout),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   assign cmd_valid = !fifo_empty;
   assign cmd_addr  = fifo_dout[2*DATA_W-1:DATA_W];
   assign cmd_req   = fifo_dout[DATA_W-1:0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         frame_err  <= 1'b0;
         frame_drop <= 1'b0;
         frame_cnt  <= '0;
         err_cnt    <= '0;
      end else begin
         frame_err  <= err;
         frame_drop <= commit && !accept;
         if (commit && accept && frame_cnt != 16'hFFFF) frame_cnt <= frame_cnt + 16'd1;
         if ((err || to_fire) && err_cnt != 16'hFFFF)   err_cnt   <= err_cnt + 16'd1;
      end
   end

`ifdef PC_CMD_PARSER_TIMEOUT_EN
   logic [15:0] idle_cnt;
   logic        active;

   // Only a partially received frame can time out; IDLE and TAIL wait freely.
   assign active  = (state == HEADER) || (state == ADDR) || (state == REQ);
   assign to_fire = active && !rx_valid && (idle_cnt == TIMEOUT_CYC - 16'd1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idle_cnt <= '0;
         timeout  <= 1'b0;
      end else begin
         timeout <= to_fire;
         if (rx_valid || to_fire) idle_cnt <= '0;
         else if (active)         idle_cnt <= idle_cnt + 16'd1;
      end
   end
`else
   assign to_fire = 1'b0;
   assign timeout = 1'b0;
`endif

endmodule

// File: doc/pc_cmd_parser.md
# pc_cmd_parser

Parametrised command-frame parser between the UART receive path and the FPGA command consumers. Takes byte strobes from the Rx module, validates header / address / request / tail framing against configurable codes and ranges, and queues each completed (address, request) pair in a small FIFO with a valid/ready output handshake. Adds error and drop reporting, frame statistics and an optional inter-byte timeout.

## Interface
- DATA_W, 8: byte width.
- HDR_CODE, 8'hFF: header code.
- TAIL_CODE, 8'h7F: tail code.
- ADDR_MIN / ADDR_MAX, 8'h01 / 8'h20: valid address range, inclusive.
- REQ_MIN / REQ_MAX, 8'h81 / 8'h88: valid request range, inclusive.
- CMD_DEPTH, 4: command FIFO depth, a power of two and at least 2.
- TIMEOUT_CYC, 16'd50000: inter-byte timeout in clk cycles.
- clk  in  1  system clock; every register is on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- rx_data  in  DATA_W  received byte.
- rx_valid  in  1  one-cycle strobe; rx_data is valid in that cycle.
- cmd_addr  out  DATA_W  address at the FIFO head.
- cmd_req  out  DATA_W  request at the FIFO head.
- cmd_valid  out  1  FIFO not empty.
- cmd_ready  in  1  consumer pop; a pop happens when cmd_valid && cmd_ready.
- frame_err  out  1  one-cycle pulse on a framing violation.
- frame_drop  out  1  one-cycle pulse when a completed frame finds the FIFO full.
- timeout  out  1  one-cycle pulse when the inter-byte timeout fires.
- frame_cnt  out  16  committed frames; saturates at 16'hFFFF.
- err_cnt  out  16  frame_err plus timeout events; saturates at 16'hFFFF.

## Operation
- FSM states: IDLE, HEADER, ADDR, REQ, TAIL. The FSM advances only in cycles where rx_valid = 1.
- IDLE: byte == HDR_CODE goes to HEADER. Any other byte is ignored silently (no error).
- HEADER:
  - byte in the address range: latch the address, go to ADDR.
  - byte == HDR_CODE: stay in HEADER.
  - any other byte: frame_err, go to IDLE.
- ADDR:
  - byte in the request range: latch the request, go to REQ.
  - byte in the address range: overwrite the address (last one wins), stay in ADDR.
  - any other byte: frame_err, go to IDLE.
- REQ:
  - byte == TAIL_CODE: commit, go to TAIL.
  - byte in the request range: overwrite the request, stay in REQ.
  - any other byte: frame_err, go to IDLE.
- TAIL:
  - byte == TAIL_CODE: ignored, stay in TAIL.
  - byte == HDR_CODE: go to HEADER (back-to-back frames).
  - any other byte: go to IDLE with no error.
- Commit:
  - FIFO not full: push {addr, req} and increment frame_cnt.
  - FIFO full: the frame is discarded, frame_drop pulses, frame_cnt unchanged.
- Push and pop in the same cycle while full: the pop frees the slot and the push is accepted.
- Push and pop in the same cycle while empty: the push is accepted and the pop has no effect.
- Range compares are unsigned and full DATA_W wide.
- Priority when codes overlap a range: HDR/TAIL match is checked first, then the request range, then the address range.
- Latched address and request are cleared to 0 whenever the FSM enters IDLE.

## Timing
- Reset values: FSM in IDLE, FIFO empty, cmd_valid = 0, cmd_addr = cmd_req = 0, frame_err = frame_drop = timeout = 0, both counters 0.
- Reset asserted mid-frame aborts the frame immediately. No error is counted and FIFO contents are lost.
- Commit latency: tail strobe in cycle N gives cmd_valid = 1 in cycle N+1, from an empty FIFO.
- cmd_addr/cmd_req are registered FIFO-head outputs and are stable while cmd_valid && !cmd_ready.
- Pop in cycle N: the next entry (or cmd_valid = 0) appears in cycle N+1.
- frame_err, frame_drop and timeout assert in the cycle after the offending strobe or event.
- Counters update in that same cycle.

## Configuration
- PC_CMD_PARSER_TIMEOUT_EN defined:
  - A 16-bit idle counter clears on every rx_valid and counts while the FSM is not in IDLE or TAIL.
  - On reaching TIMEOUT_CYC-1 the FSM goes to IDLE, timeout pulses and err_cnt increments.
  - If rx_valid arrives in that same cycle, the byte wins and no timeout fires.
- Macro undefined: no counter is built, timeout is tied to 0, and a stalled frame waits indefinitely.

## Structure
- Shared package pc_cmd_pkg holds:
  - the state enum (IDLE, HEADER, ADDR, REQ, TAIL);
  - default code constants PC_HDR_CODE, PC_TAIL_CODE, PC_ADDR_MIN/MAX, PC_REQ_MIN/MAX;
  - the command struct {addr, req}.
- One sub-module, pc_cmd_fifo: synchronous FIFO, parameters WIDTH and DEPTH, pointers one bit wider than log2(DEPTH) for full/empty detection, registered read data.
- The FSM, counters and timeout stay in pc_cmd_parser.

## Test plan
- Basic frame: FF 05 83 7F → cmd_valid one cycle after the 7F strobe, cmd_addr = 05, cmd_req = 83; frame_cnt = 1.
- Repeated codes: FF FF 03 07 82 85 7F 7F → one command {07, 85}; no frame_err.
- Bad byte: FF 05 40 → frame_err pulses once, err_cnt = 1, FSM in IDLE. A following FF 01 81 7F → command {01, 81}.
- Overflow: cmd_ready = 0, five back-to-back frames with CMD_DEPTH = 4 → four entries held, frame_drop on the fifth, frame_cnt = 4. Then four pops return the frames in order.
- Full push+pop: FIFO full, cmd_ready = 1 in the tail-commit cycle → no drop, occupancy stays at 4.
- Timeout (macro on, TIMEOUT_CYC = 100): FF 05, then 100 idle cycles → timeout pulse and IDLE. A following 83 7F produces no command.
